cmp_sel_pipe: RTL and testbench

CMP_SEL_PIPE -- requirements
Module: cmp_sel_pipe

---
 rtl/cmp_sel_pipe.sv | 118 +++++++++++
 tb/tb_cmp_sel_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sel_pipe.sv
// Two-stage compare-and-select pipeline with valid/ready handshaking.
// Emits a < b, a boolean mask, min/max of the operands, and a saturating count of lt results.
module cmp_sel_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter bit SIGNED     = 1'b0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_vld,
   output logic                  in_rd,
   output logic                  out_lt,
   output logic [DATA_WIDTH-1:0] out_mask,
   output logic [DATA_WIDTH-1:0] out_min,
   output logic [DATA_WIDTH-1:0] out_max,
   output logic                  out_vld,
   input  logic                  out_rd,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  lt_cnt
);

   logic                  s1_vld;
   logic                  s1_lt;
   logic [DATA_WIDTH-1:0] s1_a;
   logic [DATA_WIDTH-1:0] s1_b;

   logic                  s2_vld;
   logic                  s2_lt;
   logic [DATA_WIDTH-1:0] s2_mask;
   logic [DATA_WIDTH-1:0] s2_min;
   logic [DATA_WIDTH-1:0] s2_max;

   logic [CNT_WIDTH-1:0]  cnt_q;

   logic                  in_lt;
   logic                  out_xfer;
   logic                  s2_load;
   logic                  s1_moves;
   logic                  in_xfer;
   logic [DATA_WIDTH-1:0] mask_nxt;
   logic [DATA_WIDTH-1:0] min_nxt;
   logic [DATA_WIDTH-1:0] max_nxt;

   // Comparison mode is fixed at elaboration; signed mode treats the MSB as sign.
   generate
      if (SIGNED) begin : g_signed
         assign in_lt = $signed(in_a) < $signed(in_b);
      end else begin : g_unsigned
         assign in_lt = in_a < in_b;
      end
   endgenerate

   assign out_xfer = s2_vld && out_rd;
   assign s2_load  = !s2_vld || out_xfer;
   assign s1_moves = s1_vld && s2_load;
   assign in_rd    = !s1_vld || s1_moves;
   assign in_xfer  = in_vld && in_rd;

   // Select without a mux: the mask steers a to min when a < b, otherwise b.
   always_comb begin
      mask_nxt = {DATA_WIDTH{s1_lt}};
      min_nxt  = (s1_a & mask_nxt) | (s1_b & ~mask_nxt);
      max_nxt  = (s1_b & mask_nxt) | (s1_a & ~mask_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_lt  <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
      end else if (in_rd) begin
         s1_vld <= in_vld;
         if (in_xfer) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_lt <= in_lt;
         end
      end
   end

   // A stalled S2 holds its contents; lt/mask stay zero until the first real load.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld  <= 1'b0;
         s2_lt   <= 1'b0;
         s2_mask <= '0;
         s2_min  <= '0;
         s2_max  <= '0;
      end else if (s2_load) begin
         s2_vld <= s1_vld;
         if (s1_moves) begin
            s2_lt   <= s1_lt;
            s2_mask <= mask_nxt;
            s2_min  <= min_nxt;
            s2_max  <= max_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_q <= '0;
      end else if (out_xfer && s2_lt && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign out_vld  = s2_vld;
   assign out_lt   = s2_lt;
   assign out_mask = s2_mask;
   assign out_min  = s2_min;
   assign out_max  = s2_max;
   assign lt_cnt   = cnt_q;

endmodule

// File: tb/tb_cmp_sel_pipe.sv
// Scoreboard bench for cmp_sel_pipe: an unsigned and a signed instance share one stimulus stream.
// Expected results are queued at each input transfer and checked by an independent monitor.
module tb_cmp_sel_pipe;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       lt_u;
      logic       lt_s;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_vld;
   logic       out_rd;
   logic       cnt_clr;

   logic       in_rd_u, out_lt_u, out_vld_u;
   logic [7:0] out_mask_u, out_min_u, out_max_u;
   logic [3:0] lt_cnt_u;

   logic       in_rd_s, out_lt_s, out_vld_s;
   logic [7:0] out_mask_s, out_min_s, out_max_s;
   logic [15:0] lt_cnt_s;

   exp_t sb[$];
   int   total;
   int   bad;

   cmp_sel_pipe #(.DATA_WIDTH(8), .SIGNED(1'b0), .CNT_WIDTH(4)) u_uns (
      .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_vld(in_vld), .in_rd(in_rd_u),
      .out_lt(out_lt_u), .out_mask(out_mask_u), .out_min(out_min_u), .out_max(out_max_u),
      .out_vld(out_vld_u), .out_rd(out_rd), .cnt_clr(cnt_clr), .lt_cnt(lt_cnt_u)
   );

   cmp_sel_pipe #(.DATA_WIDTH(8), .SIGNED(1'b1), .CNT_WIDTH(16)) u_sgn (
      .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_vld(in_vld), .in_rd(in_rd_s),
      .out_lt(out_lt_s), .out_mask(out_mask_s), .out_min(out_min_s), .out_max(out_max_s),
      .out_vld(out_vld_s), .out_rd(out_rd), .cnt_clr(cnt_clr), .lt_cnt(lt_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the input transfer.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic ltu, input logic lts);
      int budget;
      exp_t e;
      budget = 50;
      in_a   = a;
      in_b   = b;
      in_vld = 1'b1;
      #1;
      while (!in_rd_u && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (budget == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL input accept timeout: a=0x%0h b=0x%0h", a, b);
      end else begin
         total++;
         if (in_rd_s !== in_rd_u) begin
            bad++;
            $display("[TB] FAIL in_rd agreement: signed=%0b unsigned=%0b", in_rd_s, in_rd_u);
         end
         e.a = a; e.b = b; e.lt_u = ltu; e.lt_s = lts;
         sb.push_back(e);
      end
      @(negedge clk);
      in_vld = 1'b0;
   endtask

   // Monitor: sampled just after the falling edge, when inputs for the next rising edge are settled.
   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (!rst && out_vld_u && out_rd) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected output: lt=%0b min=0x%0h max=0x%0h", out_lt_u, out_min_u, out_max_u);
         end else begin
            e = sb.pop_front();
            checkOutput("signed out_vld", 32'(out_vld_s), 32'd1);
            checkOutput("uns out_lt",   32'(out_lt_u),   32'(e.lt_u));
            checkOutput("uns out_mask", 32'(out_mask_u), e.lt_u ? 32'hFF : 32'h00);
            checkOutput("uns out_min",  32'(out_min_u),  32'(e.lt_u ? e.a : e.b));
            checkOutput("uns out_max",  32'(out_max_u),  32'(e.lt_u ? e.b : e.a));
            checkOutput("sgn out_lt",   32'(out_lt_s),   32'(e.lt_s));
            checkOutput("sgn out_mask", 32'(out_mask_s), e.lt_s ? 32'hFF : 32'h00);
            checkOutput("sgn out_min",  32'(out_min_s),  32'(e.lt_s ? e.a : e.b));
            checkOutput("sgn out_max",  32'(out_max_s),  32'(e.lt_s ? e.b : e.a));
         end
      end
   end

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      in_a    = '0;
      in_b    = '0;
      in_vld  = 1'b0;
      out_rd  = 1'b1;
      cnt_clr = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset out_vld",  32'(out_vld_u),  32'd0);
      checkOutput("reset out_lt",   32'(out_lt_u),   32'd0);
      checkOutput("reset out_mask", 32'(out_mask_u), 32'd0);
      checkOutput("reset lt_cnt",   32'(lt_cnt_u),   32'd0);
      rst = 1'b0;
      #1;
      checkOutput("in_rd after reset", 32'(in_rd_u), 32'd1);
      @(negedge clk);

      $display("[TB] basic unsigned compare and latency");
      applyStimulus(8'd3, 8'd9, 1'b1, 1'b1);
      checkOutput("latency cycle 1 out_vld", 32'(out_vld_u), 32'd0);
      @(negedge clk);
      checkOutput("latency cycle 2 out_vld", 32'(out_vld_u), 32'd1);
      @(negedge clk);
      checkOutput("lt_cnt after first lt", 32'(lt_cnt_u), 32'd1);

      $display("[TB] equal and signed vectors back-to-back");
      applyStimulus(8'h55, 8'h55, 1'b0, 1'b0);
      applyStimulus(8'h80, 8'h7F, 1'b0, 1'b1);
      applyStimulus(8'h7F, 8'h80, 1'b1, 1'b0);
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("uns lt_cnt after mixed", 32'(lt_cnt_u), 32'd2);
      checkOutput("sgn lt_cnt after mixed", 32'(lt_cnt_s), 32'd3);

      $display("[TB] backpressure");
      out_rd = 1'b0;
      fork
         begin
            applyStimulus(8'd10,  8'd20,  1'b1, 1'b1);
            applyStimulus(8'd200, 8'd100, 1'b0, 1'b1);
            applyStimulus(8'd5,   8'd5,   1'b0, 1'b0);
            applyStimulus(8'd1,   8'd2,   1'b1, 1'b1);
         end
      join_none
      repeat (6) @(negedge clk);
      checkOutput("stalled in_rd", 32'(in_rd_u), 32'd0);
      checkOutput("accepted under stall", 32'(sb.size()), 32'd2);
      checkOutput("stalled out_vld", 32'(out_vld_u), 32'd1);
      out_rd = 1'b1;
      wait fork;
      repeat (4) @(negedge clk);
      checkOutput("drained after stall", 32'(sb.size()), 32'd0);
      checkOutput("uns lt_cnt after stall", 32'(lt_cnt_u), 32'd4);
      checkOutput("sgn lt_cnt after stall", 32'(lt_cnt_s), 32'd6);

      $display("[TB] counter saturation and clear");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(8'd1, 8'd2, 1'b1, 1'b1);
      end
      repeat (4) @(negedge clk);
      checkOutput("uns lt_cnt saturated", 32'(lt_cnt_u), 32'd15);
      checkOutput("sgn lt_cnt count", 32'(lt_cnt_s), 32'd23);
      applyStimulus(8'd1, 8'd2, 1'b1, 1'b1);
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      checkOutput("uns clear wins", 32'(lt_cnt_u), 32'd0);
      checkOutput("sgn clear wins", 32'(lt_cnt_s), 32'd0);
      applyStimulus(8'd4, 8'd6, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("uns count after clear", 32'(lt_cnt_u), 32'd1);

      $display("[TB] reset with both stages full");
      out_rd = 1'b0;
      applyStimulus(8'd7, 8'd8, 1'b1, 1'b1);
      applyStimulus(8'd9, 8'd2, 1'b0, 1'b0);
      checkOutput("full pipe in_rd", 32'(in_rd_u), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid reset out_vld", 32'(out_vld_u), 32'd0);
      checkOutput("mid reset lt_cnt",  32'(lt_cnt_u),  32'd0);
      checkOutput("mid reset out_lt",  32'(out_lt_u),  32'd0);
      sb.delete();
      rst    = 1'b0;
      out_rd = 1'b1;
      #1;
      checkOutput("in_rd after mid reset", 32'(in_rd_u), 32'd1);
      repeat (8) @(negedge clk);
      applyStimulus(8'd3, 8'd9, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("lt_cnt after reset recovery", 32'(lt_cnt_u), 32'd1);
      checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
